data_mem_ctrl: RTL and testbench

//  Parametrised data memory with a valid/ready request-response handshake.

---
 rtl/data_mem_ctrl_pkg.sv | 24 ++
 rtl/data_mem_array.sv | 33 +++
 rtl/data_mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller: FSM state encoding,
// error-bit positions and the even-parity function used by the parity build.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int ERR_RANGE  = 0;
  localparam int ERR_PARITY = 1;

  // Enough for RD_LAT up to 8.
  localparam int CNT_W = 4;

  // Zero-extending a narrower word does not change its XOR reduction.
  localparam int PAR_MAX_W = 64;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage for data_mem_ctrl: synchronous write, combinational read,
// all words zero at time 0.
module data_mem_array #(
  parameter int    WIDTH     = 8,
  parameter int    IDX_W     = 5,
  parameter int    DEPTH     = 32,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset port; contents are only set by this time-0
  // clear and by writes, so data committed before an rst_n pulse is retained.
  initial begin
    for (int i = 0; i < DEPTH; i++) r_mem[i] = '0;
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples its inputs as they were before the clock edge.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// Parametrised data memory with valid/ready request/response handshake,
// range checking and configurable read latency. Define DATA_MEM_CTRL_PARITY_EN
// to store a per-word even-parity bit, check it on reads and add par_inj.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 5,
  parameter int    DEPTH     = 32,
  parameter int    RD_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              busy
`ifdef DATA_MEM_CTRL_PARITY_EN
  ,
  input  logic              par_inj
`endif
);

`ifdef DATA_MEM_CTRL_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_oor;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic [1:0]         r_rsp_err;

  logic               w_accept;
  logic               w_hs;
  logic               w_in_range;
  logic               w_enter_resp;
  logic               w_rsp_is_write;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               w_rd_oor;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_par_err;
  logic [DATA_W-1:0]  w_rdata_nxt;
  logic [1:0]         w_err_nxt;
  logic               w_mem_we;
  logic [MEM_W-1:0]   w_mem_wdata;
  logic [MEM_W-1:0]   w_mem_rdata;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b1;
    rsp_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = rst_n;
        busy      = 1'b0;
        if (req_valid && rst_n) begin
          w_state_nxt = (req_we || (RD_LAT == 1)) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept       = req_valid && req_ready;
  assign w_hs           = rsp_valid && rsp_ready;
  assign w_in_range     = {1'b0, req_addr} < DEPTH_L;
  assign w_enter_resp   = (r_state != RESP) && (w_state_nxt == RESP);
  assign w_rsp_is_write = (r_state == IDLE) && req_we;

  // ------------------------------------------------ request latch + latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_oor  <= 1'b0;
    end else if (w_accept) begin
      r_addr <= req_addr;
      r_oor  <= !w_in_range;
      if (!req_we) r_cnt <= CNT_LOAD;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A latency-1 read samples the array on the accepting edge, so the live
  // request is used in IDLE and the latched one while waiting.
  assign w_rd_addr = (r_state == IDLE) ? req_addr    : r_addr;
  assign w_rd_oor  = (r_state == IDLE) ? !w_in_range : r_oor;
  assign w_rd_data = w_mem_rdata[DATA_W-1:0];
  assign w_mem_we  = w_accept && req_we && w_in_range;

`ifdef DATA_MEM_CTRL_PARITY_EN
  assign w_mem_wdata = {parity_of(PAR_MAX_W'(req_wdata)) ^ par_inj, req_wdata};
  assign w_par_err   = parity_of(PAR_MAX_W'(w_rd_data)) != w_mem_rdata[DATA_W];
`else
  assign w_mem_wdata = req_wdata;
  assign w_par_err   = 1'b0;
`endif

  always_comb begin
    w_err_nxt             = '0;
    w_err_nxt[ERR_RANGE]  = w_rd_oor;
    w_err_nxt[ERR_PARITY] = !w_rd_oor && !w_rsp_is_write && w_par_err;
    w_rdata_nxt           = (w_rd_oor || w_rsp_is_write) ? '0 : w_rd_data;
  end

  // ------------------------------------------------------ response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
    end else if (w_enter_resp) begin
      r_rsp_rdata <= w_rdata_nxt;
      r_rsp_err   <= w_err_nxt;
    end else if (w_hs) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= '0;
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  data_mem_array #(
    .WIDTH     (MEM_W),
    .IDX_W     (IDX_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (req_addr[IDX_W-1:0]),
    .i_wdata (w_mem_wdata),
    .i_raddr (w_rd_addr[IDX_W-1:0]),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl (DEPTH=20, RD_LAT=4): directed cases
// followed by randomized traffic compared against an array-based reference model.
module tb_data_mem_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 20;
  localparam int RD_LAT = 4;
`ifdef DATA_MEM_CTRL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we    = 1'b0;
  logic [ADDR_W-1:0] req_addr  = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_ready = 1'b0;
`ifdef DATA_MEM_CTRL_PARITY_EN
  logic              par_inj   = 1'b0;
`endif
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic              busy;

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_acc    = 0;
  int     n_hs     = 0;
  int     n_overlap = 0;
  longint cyc      = 0;
  longint acc_t[$];

  // Reference model: word contents and which words hold a corrupted parity bit.
  logic [DATA_W-1:0] m_mem [2**ADDR_W];
  bit                m_bad [2**ADDR_W];

  data_mem_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
`ifdef DATA_MEM_CTRL_PARITY_EN
    ,
    .par_inj   (par_inj)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) begin
      n_acc++;
      acc_t.push_back(cyc);
    end
    if (rsp_valid && rsp_ready) n_hs++;
    if (req_ready && (busy || rsp_valid)) n_overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request from a negedge and returns at the negedge after it is accepted.
  task automatic send(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic inj);
    int w;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
`ifdef DATA_MEM_CTRL_PARITY_EN
    par_inj   = inj;
`else
    if (inj) w = 0;
`endif
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_timeout", 32'(w < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus: the DUT must rely on what it latched.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_wdata = DATA_W'($urandom);
`ifdef DATA_MEM_CTRL_PARITY_EN
    par_inj   = 1'($urandom);
`endif
  endtask

  // Called at the negedge after acceptance. hold >= 0 stalls rsp_ready for that
  // many cycles; hold < 0 drives rsp_ready with a 50% coin each cycle.
  task automatic recv(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic inj, input int hold);
    int                lat;
    int                n;
    bit                oor;
    bit                ok;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_err;
    oor = (int'(a) >= DEPTH);
    if (we) begin
      e_data = '0;
      e_err  = {1'b0, oor};
      if (!oor) begin
        m_mem[a] = d;
        m_bad[a] = inj && PAR;
      end
    end else begin
      e_data = oor ? '0 : m_mem[a];
      e_err  = {!oor && m_bad[a], oor};
    end
    ok  = 1'b1;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      ok = ok && (req_ready === 1'b0) && (busy === 1'b1);
      @(negedge clk);
      lat++;
    end
    check(we ? "wr_latency" : "rd_latency", 32'(lat), we ? 32'd1 : 32'(RD_LAT));
    check("rsp_rdata", 32'(rsp_rdata), 32'(e_data));
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    n = 0;
    while (n < 100) begin
      if (hold >= 0) begin
        if (n >= hold) break;
      end else if ($urandom_range(0, 1) == 1) begin
        break;
      end
      rsp_ready = 1'b0;
      @(negedge clk);
      n++;
      ok = ok && (rsp_valid === 1'b1) && (rsp_rdata === e_data) && (rsp_err === e_err)
              && (req_ready === 1'b0) && (busy === 1'b1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stable_while_pending", 32'(ok), 32'd1);
    check("idle_after_handshake", 32'({rsp_valid, busy, req_ready}), 32'b001);
  endtask

  task automatic xact(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic inj, input int hold);
    send(we, a, d, inj);
    recv(we, a, d, inj, hold);
  endtask

  initial begin
    int w;
    int base;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'({req_ready, rsp_valid, busy}), 32'b000);
    check("reset_rsp", 32'({rsp_rdata, rsp_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'({req_ready, busy}), 32'b10);

    // Basic write then read
    xact(1'b1, 5'd3, 8'hA5, 1'b0, 0);
    xact(1'b0, 5'd3, 8'h00, 1'b0, 0);

    // Out-of-range write and read, then a full dump of implemented words
    xact(1'b1, 5'd25, 8'h11, 1'b0, 0);
    xact(1'b0, 5'd25, 8'h00, 1'b0, 0);
    xact(1'b1, 5'd20, 8'h77, 1'b0, 0);
    xact(1'b1, 5'd19, 8'h5A, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) xact(1'b0, ADDR_W'(i), 8'h00, 1'b0, 0);

    // Back-pressured read
    xact(1'b0, 5'd3, 8'h00, 1'b0, 6);

    // Reset mid-WAIT discards the pending read but keeps committed data
    xact(1'b1, 5'd7, 8'h3C, 1'b0, 0);
    send(1'b0, 5'd7, 8'h00, 1'b0);
    check("in_wait", 32'({busy, rsp_valid}), 32'b10);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_wait", 32'({rsp_valid, busy, req_ready}), 32'b000);
    @(negedge clk);
    check("reset_mid_wait_rsp", 32'({rsp_rdata, rsp_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 5'd7, 8'h00, 1'b0, 0);

    // Parity injection (error only in the parity build)
    xact(1'b1, 5'd1, 8'h0F, 1'b1, 0);
    xact(1'b0, 5'd1, 8'h00, 1'b0, 0);
    xact(1'b1, 5'd1, 8'h0F, 1'b0, 0);
    xact(1'b0, 5'd1, 8'h00, 1'b0, 0);

    // Read throughput with rsp_ready held high
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd3;
    base = n_acc;
    w = 0;
    while (n_acc < base + 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    rsp_ready = 1'b0;
    check("throughput_done", 32'(w < 100), 32'd1);
    check("read_period", 32'(acc_t[$] - acc_t[$-1]), 32'(RD_LAT + 1));

    // Randomized traffic with throttled responses
    for (int k = 0; k < 200; k++) begin
      logic              we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              inj;
      we  = 1'($urandom);
      a   = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
      d   = DATA_W'($urandom);
      inj = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xact(we, a, d, inj, -1);
    end

    // Exactly one response was discarded by the mid-WAIT reset
    check("acc_vs_rsp", 32'(n_acc - n_hs), 32'd1);
    check("one_outstanding", 32'(n_overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
